// File: rtl/hex_multi_display.sv
// hex_multi_display
//   Drives NUM_DIGITS active-low seven-segment displays from one packed hex
//   value held in a display register. Supports leading-zero blanking,
//   per-digit blinking and a periodic left-rotate scroll. The segment
//   outputs are registered, so no input reaches hex_o combinationally.
//
// Ports
//   clk_i         system clock, everything on the rising edge
//   reset_i       synchronous, active-high reset
//   load_i        capture data_i into the display register
//   data_i        packed value, digit i = data_i[4i+3:4i], digit 0 rightmost
//   blank_lz_i    1 = blank leading zeros (digit 0 is always shown)
//   blink_mask_i  1 = digit i blinks with the blink phase
//   scroll_en_i   1 = rotate digits left once every SCROLL_DIV cycles
//   hex_o         active-low segments, digit i = hex_o[7i+6:7i], bits gfedcba
module hex_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCROLL_DIV = 50_000_000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic                    scroll_en_i,
    output logic [7*NUM_DIGITS-1:0] hex_o
);

    localparam int DW  = 4 * NUM_DIGITS;
    localparam int HW  = 7 * NUM_DIGITS;
    localparam int BCW = $clog2(BLINK_DIV);
    localparam int SCW = $clog2(SCROLL_DIV);

    localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_DIV - 1);
    localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_DIV - 1);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DW-1:0]  dreg_q, dreg_d, rot;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_on_q, blink_on_d;
    logic [SCW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic [HW-1:0]  hex_q, hex_d;
    logic           blink_wrap, scroll_wrap;

    // Left rotate by one digit: digit i takes digit i-1, digit 0 takes the top digit.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            rot[4*i +: 4] = dreg_q[4*((i + NUM_DIGITS - 1) % NUM_DIGITS) +: 4];
        end
    end

    // Counter / display-register next state
    always_comb begin
        blink_wrap   = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d  = blink_wrap ? '0 : blink_cnt_q + BCW'(1);
        blink_on_d   = blink_on_q ^ blink_wrap;

        scroll_wrap  = scroll_en_i && (scroll_cnt_q == SCROLL_LAST);
        scroll_cnt_d = (!scroll_en_i || scroll_wrap) ? '0 : scroll_cnt_q + SCW'(1);

        // A load on a wrap cycle wins; the counter still wraps.
        if (load_i)           dreg_d = data_i;
        else if (scroll_wrap) dreg_d = rot;
        else                  dreg_d = dreg_q;
    end

    // Segment stage: decode from the registered display state
    always_comb begin
        logic [3:0] digit;
        logic       upper_zero;
        logic       blank;
        digit      = '0;
        blank      = 1'b0;
        upper_zero = 1'b1;
        hex_d      = '0;
        // Walk from the top digit down so upper_zero means "this digit and all above are 0".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit      = dreg_q[4*i +: 4];
            upper_zero = upper_zero && (digit == 4'h0);
            blank      = (blink_mask_i[i] && !blink_on_q) ||
                         (blank_lz_i && (i > 0) && upper_zero);
            hex_d[7*i +: 7] = blank ? 7'h7F : seg7(digit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dreg_q       <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            scroll_cnt_q <= '0;
            hex_q        <= {NUM_DIGITS{7'h4C}};
        end else begin
            dreg_q       <= dreg_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            scroll_cnt_q <= scroll_cnt_d;
            hex_q        <= hex_d;
        end
    end

    assign hex_o = hex_q;

endmodule
